// File: rtl/pipeline_controller_if.sv
// Stall/flush control bundle between the hazard sources and the pipeline.
// master: the controller (hazard/memory status in, enables/flushes/counters out); slave: the other side.
interface pipeline_controller_if #(
   parameter int CNT_W = 16
);
   logic             ihit;
   logic             dhit;
   logic             dmem_req_M;
   logic             lw_hazard;
   logic             mispredict_M;
   logic             halt_M;
   logic             pc_en;
   logic             en_IFID;
   logic             en_IDEX;
   logic             en_EXMEM;
   logic             en_MEMWB;
   logic             flush_IFID;
   logic             flush_IDEX;
   logic             flush_EXMEM;
   logic             mem_busy;
   logic             halt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic [CNT_W-1:0] bubble_cnt;

   modport master (
      input  ihit, dhit, dmem_req_M, lw_hazard, mispredict_M, halt_M,
      output pc_en, en_IFID, en_IDEX, en_EXMEM, en_MEMWB,
      output flush_IFID, flush_IDEX, flush_EXMEM, mem_busy, halt,
      output stall_cnt, flush_cnt, bubble_cnt
   );

   modport slave (
      output ihit, dhit, dmem_req_M, lw_hazard, mispredict_M, halt_M,
      input  pc_en, en_IFID, en_IDEX, en_EXMEM, en_MEMWB,
      input  flush_IFID, flush_IDEX, flush_EXMEM, mem_busy, halt,
      input  stall_cnt, flush_cnt, bubble_cnt
   );
endinterface

// File: rtl/pipeline_controller.sv
// Five-stage pipeline stall/flush sequencer with sticky halt and saturating event counters.
// Ports: CLK, nRST (sync, active-low), bus (pipeline_controller_if.master).
module pipeline_controller #(
   parameter int CNT_W = 16
) (
   input  logic                  CLK,
   input  logic                  nRST,
   pipeline_controller_if.master bus
);
   typedef enum logic [1:0] {RUN, DWAIT, BUBBLE, HALT} state_t;

   state_t           state, state_n;
   logic             pc_en, en_ifid, en_idex, en_exmem, en_memwb;
   logic             fl_ifid, fl_idex, fl_exmem;
   logic             stall_inc, flush_inc, bubble_inc;
   logic             dmiss;
   logic [CNT_W-1:0] stall_cnt, flush_cnt, bubble_cnt;

   // DWAIT keeps freezing until dhit even if the request line drops.
   assign dmiss = !bus.dhit && (bus.dmem_req_M || state == DWAIT);

   always_comb begin
      state_n    = state;
      pc_en      = 1'b0;
      en_ifid    = 1'b0;
      en_idex    = 1'b0;
      en_exmem   = 1'b0;
      en_memwb   = 1'b0;
      fl_ifid    = 1'b0;
      fl_idex    = 1'b0;
      fl_exmem   = 1'b0;
      stall_inc  = 1'b0;
      flush_inc  = 1'b0;
      bubble_inc = 1'b0;
      if (!nRST) begin
         state_n = RUN;
      end else if (state == HALT) begin
         state_n = HALT;
      end else if (bus.halt_M) begin
         state_n = HALT;
      end else if (dmiss) begin
         state_n   = DWAIT;
         stall_inc = 1'b1;
      end else if (bus.mispredict_M) begin
         pc_en     = 1'b1;
         en_ifid   = 1'b1;
         en_idex   = 1'b1;
         en_exmem  = 1'b1;
         en_memwb  = 1'b1;
         fl_ifid   = 1'b1;
         fl_idex   = 1'b1;
         fl_exmem  = 1'b1;
         state_n   = RUN;
         flush_inc = 1'b1;
      end else if (bus.lw_hazard && state != BUBBLE) begin
         // One bubble per load: BUBBLE ignores the still-asserted hazard.
         en_idex    = 1'b1;
         fl_idex    = 1'b1;
         en_exmem   = 1'b1;
         en_memwb   = 1'b1;
         state_n    = BUBBLE;
         bubble_inc = 1'b1;
      end else if (!bus.ihit) begin
         en_ifid   = 1'b1;
         fl_ifid   = 1'b1;
         en_idex   = 1'b1;
         en_exmem  = 1'b1;
         en_memwb  = 1'b1;
         state_n   = RUN;
         stall_inc = 1'b1;
      end else begin
         pc_en    = 1'b1;
         en_ifid  = 1'b1;
         en_idex  = 1'b1;
         en_exmem = 1'b1;
         en_memwb = 1'b1;
         state_n  = RUN;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state      <= RUN;
         stall_cnt  <= '0;
         flush_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         state <= state_n;
         if (stall_inc && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_inc && flush_cnt != '1)
            flush_cnt <= flush_cnt + CNT_W'(1);
         if (bubble_inc && bubble_cnt != '1)
            bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

   assign bus.pc_en       = pc_en;
   assign bus.en_IFID     = en_ifid;
   assign bus.en_IDEX     = en_idex;
   assign bus.en_EXMEM    = en_exmem;
   assign bus.en_MEMWB    = en_memwb;
   assign bus.flush_IFID  = fl_ifid;
   assign bus.flush_IDEX  = fl_idex;
   assign bus.flush_EXMEM = fl_exmem;
   assign bus.mem_busy    = (state == DWAIT);
   assign bus.halt        = (state == HALT);
   assign bus.stall_cnt   = stall_cnt;
   assign bus.flush_cnt   = flush_cnt;
   assign bus.bubble_cnt  = bubble_cnt;
endmodule
